// File: rtl/mod_atan2_16_if.sv
// mod_atan2_16_if -- request/response bundle for the atan2 block.
// The requester drives the sample pair and valid and accepts the phase;
// the block drives ready, the phase result and its valid flag.
interface mod_atan2_16_if;
   logic signed [15:0] i_x;
   logic signed [15:0] i_y;
   logic               i_valid;
   logic               o_ready;
   logic signed [15:0] o_angle;
   logic               o_valid;
   logic               i_ready;

   modport master (
      output i_x, i_y, i_valid, i_ready,
      input  o_ready, o_angle, o_valid
   );

   modport slave (
      input  i_x, i_y, i_valid, i_ready,
      output o_ready, o_angle, o_valid
   );
endinterface

// File: rtl/mod_atan2_16.sv
// mod_atan2_16 -- iterative CORDIC vectoring atan2.
// One request at a time: accept in IDLE, ITER micro-rotations in ROT,
// hold the phase in DONE until the consumer takes it.
// Phase format: 0x2000 = pi/2, 0x4000 = pi; result range (-0x4000, 0x4000].
module mod_atan2_16 #(
   parameter int ITER = 14
) (
   input  logic           i_clk,
   input  logic           i_rst,
   mod_atan2_16_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ROT  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // z carries two extra fractional bits: pi/2 = 32768, pi/4 = 16384
   localparam logic signed [18:0] Z_HALF_PI = 19'sd32768;

   logic [1:0]         state;
   logic [4:0]         iter;
   logic signed [18:0] x;
   logic signed [18:0] y;
   logic signed [18:0] z;
   logic               zero_in;
   logic signed [15:0] angle;

   logic signed [18:0] x_sh;
   logic signed [18:0] y_sh;
   logic signed [18:0] x_nx;
   logic signed [18:0] y_nx;
   logic signed [18:0] z_nx;

   logic signed [18:0] cx;
   logic signed [18:0] cy;

   // atan(2^-i) in z units (pi/65536 per LSB), rounded to nearest
   function automatic logic signed [18:0] atan_tab(input logic [4:0] i);
      case (i)
         5'd0:    atan_tab = 19'sd16384;
         5'd1:    atan_tab = 19'sd9672;
         5'd2:    atan_tab = 19'sd5110;
         5'd3:    atan_tab = 19'sd2594;
         5'd4:    atan_tab = 19'sd1302;
         5'd5:    atan_tab = 19'sd652;
         5'd6:    atan_tab = 19'sd326;
         5'd7:    atan_tab = 19'sd163;
         5'd8:    atan_tab = 19'sd81;
         5'd9:    atan_tab = 19'sd41;
         5'd10:   atan_tab = 19'sd20;
         5'd11:   atan_tab = 19'sd10;
         5'd12:   atan_tab = 19'sd5;
         5'd13:   atan_tab = 19'sd3;
         5'd14:   atan_tab = 19'sd1;
         5'd15:   atan_tab = 19'sd1;
         default: atan_tab = 19'sd0;
      endcase
   endfunction

   // Drop the two guard bits with round-half-up, then clamp into the
   // half-open phase range; exactly -pi is reported as +pi.
   function automatic logic signed [15:0] round_sat(input logic signed [18:0] zf);
      logic signed [18:0] r;
      r = (zf + 19'sd2) >>> 2;
      if (r >= 19'sd16384)
         round_sat = 16'sh4000;
      else if (r == -19'sd16384)
         round_sat = 16'sh4000;
      else if (r < -19'sd16384)
         round_sat = -16'sh3FFF;
      else
         round_sat = r[15:0];
   endfunction

   // Sign-extend the captured samples into the 19-bit working width
   always_comb begin
      cx = {{3{bus.i_x[15]}}, bus.i_x};
      cy = {{3{bus.i_y[15]}}, bus.i_y};
   end

   // One micro-rotation driving y toward zero, using pre-update x/y
   always_comb begin
      x_sh = x >>> iter;
      y_sh = y >>> iter;
      x_nx = x;
      y_nx = y;
      z_nx = z;
      if (y >= 19'sd0) begin
         x_nx = x + y_sh;
         y_nx = y - x_sh;
         z_nx = z + atan_tab(iter);
      end else begin
         x_nx = x - y_sh;
         y_nx = y + x_sh;
         z_nx = z - atan_tab(iter);
      end
   end

   // Control FSM plus working registers; reset aborts any operation
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= S_IDLE;
         iter    <= 5'd0;
         x       <= 19'sd0;
         y       <= 19'sd0;
         z       <= 19'sd0;
         zero_in <= 1'b0;
         angle   <= 16'sd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.i_valid) begin
                  iter    <= 5'd0;
                  zero_in <= (bus.i_x == 16'sd0) && (bus.i_y == 16'sd0);
                  state   <= S_ROT;
                  // Fold the left half-plane into the right so CORDIC converges
                  if (!cx[18]) begin
                     x <= cx;
                     y <= cy;
                     z <= 19'sd0;
                  end else if (!cy[18]) begin
                     x <= cy;
                     y <= -cx;
                     z <= Z_HALF_PI;
                  end else begin
                     x <= -cy;
                     y <= cx;
                     z <= -Z_HALF_PI;
                  end
               end
            end
            S_ROT: begin
               x    <= x_nx;
               y    <= y_nx;
               z    <= z_nx;
               iter <= iter + 5'd1;
               if (iter == 5'(ITER - 1)) begin
                  state <= S_DONE;
                  // A zero vector has no direction; report phase 0
                  angle <= zero_in ? 16'sd0 : round_sat(z_nx);
               end
            end
            S_DONE: begin
               if (bus.i_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_ready = (state == S_IDLE) && !i_rst;
   assign bus.o_valid = (state == S_DONE);
   assign bus.o_angle = angle;

endmodule
